// File: rtl/keccak_pre_theta_gen.sv
// rtl/keccak_pre_theta_gen.sv - slice prefetch for the slice-serial Keccak-f[1600] core
// Gathers post-rho/pi bits of the next round's first slices, then applies chi+iota.
module keccak_pre_theta_gen #(
  parameter int LANE_W  = 64,
  parameter int SPW     = 8,
  parameter int N_PRE   = 1,
  parameter int NUM_RND = 24,
  localparam int SW = $clog2(LANE_W / SPW),
  localparam int WW = 25 * SPW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pre_en,
  input  logic [WW-1:0]        k_ram_o_all,
  input  logic [WW-1:0]        k_ram_i_all,
  input  logic [WW-1:0]        ci_out,
  input  logic [N_PRE-1:0]     pre_rnd,
  input  logic [SW-1:0]        Sub_Rnd_cnt,
  input  logic [4:0]           Rnd_cnt,
  input  logic                 pre_take,
  output logic                 pre_vld,
  output logic [25*N_PRE-1:0]  pre_theta,
  output logic                 pre_err
);

  localparam int NB = 25 * N_PRE;
  localparam int NSUB = LANE_W / SPW;
  localparam logic [SW-1:0] SUB_LAST = SW'(NSUB - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, GATHER = 2'd1, HOLD = 2'd2} state_t;

  // Standard rho offsets indexed by lane x+5y.
  function automatic int rho_off(input int idx);
    case (idx)
      0: return 0;   1: return 1;   2: return 62;  3: return 28;  4: return 27;
      5: return 36;  6: return 44;  7: return 6;   8: return 55;  9: return 20;
      10: return 3;  11: return 10; 12: return 43; 13: return 25; 14: return 39;
      15: return 41; 16: return 45; 17: return 15; 18: return 21; 19: return 8;
      20: return 18; 21: return 2;  22: return 61; 23: return 56; default: return 14;
    endcase
  endfunction

  state_t            state, state_n;
  logic [NB-1:0]     gath, mask, fwd;
  logic [NB-1:0]     cap_hit, cap_bit, fwd_n, chi_o, gath_n, mask_n;
  logic [N_PRE-1:0]  rc_q;
  logic              sel_q;
  logic              cap_en, mask_clr, err_set;
  logic [WW-1:0]     fwd_word;
  logic              unused_bits;

  // Each prefetched bit has one fixed source position and one sub-round where it appears.
  for (genvar s = 0; s < N_PRE; s++) begin : g_slice
    for (genvar y = 0; y < 5; y++) begin : g_row
      for (genvar x = 0; x < 5; x++) begin : g_col
        localparam int SI = ((x + 3 * y) % 5) + 5 * x;
        localparam int R  = rho_off(SI) % LANE_W;
        localparam int Z  = (s + LANE_W - R) % LANE_W;
        assign cap_hit[s*25 + x + 5*y] = (Sub_Rnd_cnt == SW'(Z / SPW));
        assign cap_bit[s*25 + x + 5*y] = k_ram_i_all[SI*SPW + (Z % SPW)];
      end
    end
  end

  assign unused_bits = ^{k_ram_o_all, k_ram_i_all, ci_out};
  assign fwd_word = (Rnd_cnt == 5'd0) ? k_ram_o_all : ci_out;

  always_comb begin
    state_n  = state;
    cap_en   = 1'b0;
    mask_clr = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (Sub_Rnd_cnt == '0) begin
          state_n  = GATHER;
          cap_en   = 1'b1;
          mask_clr = 1'b1;
        end
      end
      GATHER: begin
        cap_en = 1'b1;
        if (Sub_Rnd_cnt == SUB_LAST) begin
          state_n = HOLD;
          err_set = ~&(mask | cap_hit);
        end
      end
      HOLD: begin
        if (pre_take) begin
          if (Sub_Rnd_cnt == '0) begin
            state_n  = GATHER;
            cap_en   = 1'b1;
            mask_clr = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (!pre_en) begin
      state_n  = IDLE;
      cap_en   = 1'b0;
      mask_clr = 1'b0;
      err_set  = 1'b0;
    end
  end

  always_comb begin
    mask_n = (mask_clr ? '0 : mask) | (cap_en ? cap_hit : '0);
    gath_n = cap_en ? ((gath & ~cap_hit) | (cap_bit & cap_hit)) : gath;
    fwd_n  = '0;
    for (int s = 0; s < N_PRE; s++) begin
      for (int i = 0; i < 25; i++) begin
        fwd_n[s*25 + i] = fwd_word[i*SPW + s];
      end
    end
  end

  // chi along each 5-lane row of a slice, then iota on lane 0.
  always_comb begin
    chi_o = '0;
    for (int s = 0; s < N_PRE; s++) begin
      for (int y = 0; y < 5; y++) begin
        for (int x = 0; x < 5; x++) begin
          chi_o[s*25 + x + 5*y] = gath[s*25 + x + 5*y]
                                ^ (~gath[s*25 + ((x + 1) % 5) + 5*y]
                                   & gath[s*25 + ((x + 2) % 5) + 5*y]);
        end
      end
      chi_o[s*25] = chi_o[s*25] ^ rc_q[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gath    <= '0;
      mask    <= '0;
      fwd     <= '0;
      rc_q    <= '0;
      sel_q   <= 1'b0;
      pre_err <= 1'b0;
    end else begin
      state <= state_n;
      if (err_set) pre_err <= 1'b1;
      if (!pre_en) begin
        gath  <= '0;
        mask  <= '0;
        fwd   <= '0;
        rc_q  <= '0;
        sel_q <= 1'b0;
      end else begin
        gath  <= gath_n;
        mask  <= mask_n;
        fwd   <= fwd_n;
        rc_q  <= pre_rnd;
        sel_q <= (Sub_Rnd_cnt == SUB_LAST) && (Rnd_cnt != 5'd0)
                 && (int'(Rnd_cnt) < NUM_RND);
      end
    end
  end

  assign pre_vld   = (state == HOLD);
  assign pre_theta = sel_q ? chi_o : fwd;

endmodule

// File: tb/tb_keccak_pre_theta_gen.sv
// tb/tb_keccak_pre_theta_gen.sv - self-checking bench for keccak_pre_theta_gen
// Two instances: 8 slices/word with 1 prefetched slice, 4 slices/word with 2.
module tb_keccak_pre_theta_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         a_en, a_take, a_rc, a_vld, a_err;
  logic [199:0] a_o, a_i, a_ci;
  logic [2:0]   a_sub;
  logic [4:0]   a_rnd;
  logic [24:0]  a_theta;

  logic         b_en, b_take, b_vld, b_err;
  logic [1:0]   b_rc;
  logic [99:0]  b_o, b_i, b_ci;
  logic [3:0]   b_sub;
  logic [4:0]   b_rnd;
  logic [49:0]  b_theta;

  keccak_pre_theta_gen dut_a (
    .clk(clk), .rst(rst), .pre_en(a_en), .k_ram_o_all(a_o), .k_ram_i_all(a_i),
    .ci_out(a_ci), .pre_rnd(a_rc), .Sub_Rnd_cnt(a_sub), .Rnd_cnt(a_rnd),
    .pre_take(a_take), .pre_vld(a_vld), .pre_theta(a_theta), .pre_err(a_err)
  );

  keccak_pre_theta_gen #(.LANE_W(64), .SPW(4), .N_PRE(2)) dut_b (
    .clk(clk), .rst(rst), .pre_en(b_en), .k_ram_o_all(b_o), .k_ram_i_all(b_i),
    .ci_out(b_ci), .pre_rnd(b_rc), .Sub_Rnd_cnt(b_sub), .Rnd_cnt(b_rnd),
    .pre_take(b_take), .pre_vld(b_vld), .pre_theta(b_theta), .pre_err(b_err)
  );

  int n_pass = 0;
  int n_tot  = 0;

  int rho_t [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                     41, 45, 15, 21, 8, 18, 2, 61, 56, 14};
  logic [63:0] lanes [25];

  typedef struct {
    logic [4:0]  rnd;
    logic [2:0]  sub;
    logic [7:0]  oe, oo, ce, co;
    logic [24:0] exp;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] v, input int r);
    int rr;
    rr = r % 64;
    if (rr == 0) return v;
    return (v << rr) | (v >> (64 - rr));
  endfunction

  // Reference: full-lane rho/pi of the gathered state, then chi and iota on one slice.
  function automatic logic [24:0] golden(input int s, input bit rc);
    logic [24:0] b, o;
    logic [63:0] v;
    int src;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) begin
        src = (x + 3 * y) % 5 + 5 * x;
        v = rotl(lanes[src], rho_t[src]);
        b[x + 5*y] = v[s];
      end
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        o[x + 5*y] = b[x + 5*y] ^ (~b[(x+1)%5 + 5*y] & b[(x+2)%5 + 5*y]);
    o[0] = o[0] ^ rc;
    return o;
  endfunction

  function automatic logic [199:0] word_a(input int t);
    logic [199:0] w;
    w = '0;
    for (int i = 0; i < 25; i++)
      for (int j = 0; j < 8; j++) w[i*8 + j] = lanes[i][t*8 + j];
    return w;
  endfunction

  function automatic logic [99:0] word_b(input int t);
    logic [99:0] w;
    w = '0;
    for (int i = 0; i < 25; i++)
      for (int j = 0; j < 4; j++) w[i*4 + j] = lanes[i][t*4 + j];
    return w;
  endfunction

  function automatic logic [199:0] rnd_w();
    logic [199:0] w;
    w = '0;
    for (int k = 0; k < 7; k++) w = {w[167:0], $urandom};
    return w;
  endfunction

  function automatic logic [199:0] mkw(input logic [7:0] ev, input logic [7:0] od);
    logic [199:0] w;
    for (int i = 0; i < 25; i++) w[i*8 +: 8] = (i % 2 == 1) ? od : ev;
    return w;
  endfunction

  task automatic new_lanes();
    for (int i = 0; i < 25; i++) lanes[i] = {$urandom, $urandom};
  endtask

  task automatic sweep_a(input int rnd, input bit rc, input bit take0, input int skip,
                         input int t_from, input int t_to);
    for (int t = t_from; t <= t_to; t++) begin
      if (t == skip) continue;
      a_sub  = 3'(t);
      a_i    = word_a(t);
      a_o    = rnd_w();
      a_ci   = rnd_w();
      a_rnd  = 5'(rnd);
      a_rc   = rc;
      a_take = (t == 0) ? take0 : 1'b0;
      cyc();
      if (t == 0 && take0) chk("a_take_regather_vld", a_vld, 0);
    end
    a_take = 1'b0;
  endtask

  task automatic sweep_b(input int rnd, input logic [1:0] rc, input bit take0);
    logic [199:0] r;
    for (int t = 0; t < 16; t++) begin
      b_sub  = 4'(t);
      b_i    = word_b(t);
      r = rnd_w();
      b_o    = r[99:0];
      b_ci   = r[199:100];
      b_rnd  = 5'(rnd);
      b_rc   = rc;
      b_take = (t == 0) ? take0 : 1'b0;
      cyc();
      if (t == 0 && take0) chk("b_take_regather_vld", b_vld, 0);
    end
    b_take = 1'b0;
  endtask

  initial begin
    logic [24:0] g, saved;
    logic [199:0] w;
    logic [24:0] e;
    bit rc;
    logic [1:0] rc2;
    int rnd;

    tbl[0] = '{5'd0, 3'd7, 8'hA5, 8'hA5, 8'h00, 8'h00, 25'h1FFFFFF};
    tbl[1] = '{5'd0, 3'd2, 8'h5A, 8'h5A, 8'hFF, 8'hFF, 25'h0000000};
    tbl[2] = '{5'd5, 3'd3, 8'hFF, 8'hFF, 8'h01, 8'h01, 25'h1FFFFFF};
    tbl[3] = '{5'd5, 3'd1, 8'h01, 8'h01, 8'hFE, 8'hFE, 25'h0000000};
    tbl[4] = '{5'd0, 3'd4, 8'h00, 8'h01, 8'hFF, 8'hFF, 25'h0AAAAAA};
    tbl[5] = '{5'd9, 3'd5, 8'hFF, 8'hFF, 8'h01, 8'h00, 25'h1555555};
    tbl[6] = '{5'd7, 3'd7, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 25'h0000000};

    // Reset with random inputs applied.
    rst = 1'b1;
    a_en = 1'b1; a_take = 1'b1; a_rc = 1'b1; a_sub = 3'd0; a_rnd = 5'd3;
    a_o = rnd_w(); a_i = rnd_w(); a_ci = rnd_w();
    b_en = 1'b1; b_take = 1'b1; b_rc = 2'b11; b_sub = 4'd0; b_rnd = 5'd3;
    w = rnd_w(); b_o = w[99:0]; b_i = w[199:100]; b_ci = w[150:51];
    cyc();
    a_sub = 3'd7; b_sub = 4'd15;
    cyc();
    chk("rst_a_vld", a_vld, 0);   chk("rst_a_err", a_err, 0);
    chk("rst_a_theta", a_theta, 0);
    chk("rst_b_vld", b_vld, 0);   chk("rst_b_err", b_err, 0);
    chk("rst_b_theta", b_theta, 0);
    rst = 1'b0;
    a_take = 1'b0; a_rc = 1'b0; b_en = 1'b0; b_take = 1'b0;

    // Forward path table, kept away from sub-round 0 so the FSM idles.
    a_en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      a_rnd = tbl[k].rnd; a_sub = tbl[k].sub;
      a_o = mkw(tbl[k].oe, tbl[k].oo); a_ci = mkw(tbl[k].ce, tbl[k].co);
      cyc();
      chk($sformatf("tbl%0d_theta", k), a_theta, tbl[k].exp);
      chk($sformatf("tbl%0d_vld", k), a_vld, 0);
    end

    for (int k = 0; k < 8; k++) begin
      a_rnd = 5'($urandom_range(0, 23)); a_sub = 3'($urandom_range(1, 6));
      a_o = rnd_w(); a_ci = rnd_w();
      w = (a_rnd == 0) ? a_o : a_ci;
      for (int i = 0; i < 25; i++) e[i] = w[i*8];
      cyc();
      chk($sformatf("fwd_rand%0d", k), a_theta, e);
    end

    // Round 3 gather with rc=1.
    new_lanes();
    sweep_a(3, 1'b1, 1'b0, -1, 0, 7);
    chk("r3_theta", a_theta, golden(0, 1'b1));
    chk("r3_vld", a_vld, 1);
    chk("r3_err", a_err, 0);

    // Back-to-back sweeps, each taken at sub-round 0.
    for (int k = 0; k < 6; k++) begin
      rnd = 4 + k; rc = 1'($urandom);
      new_lanes();
      sweep_a(rnd, rc, 1'b1, -1, 0, 7);
      chk($sformatf("seq%0d_theta", k), a_theta, golden(0, rc));
      chk($sformatf("seq%0d_vld", k), a_vld, 1);
    end

    // Final round: held, not taken, gathered bits stay frozen.
    rc = 1'($urandom);
    new_lanes();
    sweep_a(23, rc, 1'b1, -1, 0, 7);
    saved = golden(0, rc);
    chk("r23_theta", a_theta, saved);
    new_lanes();
    sweep_a(23, rc, 1'b0, -1, 0, 7);
    chk("r23_frozen_theta", a_theta, saved);
    chk("r23_still_vld", a_vld, 1);

    // Abort at sub-round 4.
    a_en = 1'b0; cyc(); a_en = 1'b1;
    new_lanes();
    sweep_a(6, 1'b0, 1'b0, -1, 0, 3);
    a_sub = 3'd4; a_en = 1'b0;
    cyc();
    chk("abort_vld", a_vld, 0);
    chk("abort_theta", a_theta, 0);
    a_en = 1'b1;
    sweep_a(6, 1'b0, 1'b0, -1, 5, 7);
    chk("abort_no_hold", a_vld, 0);
    rc = 1'($urandom);
    new_lanes();
    sweep_a(6, rc, 1'b0, -1, 0, 7);
    chk("resume_theta", a_theta, golden(0, rc));
    chk("resume_vld", a_vld, 1);

    // Skipped sub-round 3 leaves the mask incomplete.
    a_en = 1'b0; cyc(); a_en = 1'b1;
    new_lanes();
    sweep_a(8, 1'b0, 1'b0, 3, 0, 7);
    chk("skip_err", a_err, 1);
    chk("skip_vld", a_vld, 1);
    a_en = 1'b0; cyc();
    chk("skip_err_after_abort", a_err, 1);
    chk("skip_vld_after_abort", a_vld, 0);
    a_en = 1'b1;
    rc = 1'($urandom);
    new_lanes();
    sweep_a(8, rc, 1'b0, -1, 0, 7);
    chk("skip_next_theta", a_theta, golden(0, rc));
    chk("skip_err_sticky", a_err, 1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("skip_err_rst", a_err, 0);
    chk("skip_vld_rst", a_vld, 0);
    a_en = 1'b0;

    // Two prefetched slices with four slices per word.
    b_en = 1'b1;
    rc2 = 2'($urandom);
    new_lanes();
    sweep_b(2, rc2, 1'b0);
    chk("b_first_theta", b_theta, {golden(1, rc2[1]), golden(0, rc2[0])});
    chk("b_first_vld", b_vld, 1);
    for (int k = 0; k < 3; k++) begin
      rc2 = 2'($urandom);
      new_lanes();
      sweep_b(10 + k, rc2, 1'b1);
      chk($sformatf("b_seq%0d_theta", k), b_theta, {golden(1, rc2[1]), golden(0, rc2[0])});
      chk($sformatf("b_seq%0d_vld", k), b_vld, 1);
    end
    chk("b_err", b_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
